// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
// The slave modport is the controller's view; master is the pipeline's view.
interface pipe_ctrl_if #(
    parameter int N_STAGES = 5,
    parameter int ADDR_W   = 32
);
    logic [N_STAGES-1:0] hold_req_i;
    logic                jump_en_i;
    logic [ADDR_W-1:0]   jump_addr_i;
    logic [N_STAGES-1:0] stall_o;
    logic [N_STAGES-1:0] flush_o;
    logic                pc_hold_o;
    logic                jump_en_o;
    logic [ADDR_W-1:0]   jump_addr_o;
    logic                hold_timeout_o;
    logic [31:0]         stall_cnt_o;
    logic [31:0]         flush_cnt_o;

    modport slave (
        input  hold_req_i, jump_en_i, jump_addr_i,
        output stall_o, flush_o, pc_hold_o, jump_en_o, jump_addr_o,
        output hold_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output hold_req_i, jump_en_i, jump_addr_i,
        input  stall_o, flush_o, pc_hold_o, jump_en_o, jump_addr_o,
        input  hold_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage stall/flush, registered PC redirect, stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall/redirect performance counters.
module pipe_ctrl #(
    parameter int N_STAGES     = 5,
    parameter int ADDR_W       = 32,
    parameter int JUMP_STAGE   = 2,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [N_STAGES-1:0] ONE_V     = {{(N_STAGES-1){1'b0}}, 1'b1};
    localparam logic [N_STAGES-1:0] JUMP_MASK = (ONE_V << JUMP_STAGE) - ONE_V;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    hold_cnt_r;
    logic [CNT_W-1:0]    hold_cnt_nxt_s;
    logic                hold_timeout_r;
    logic                jump_en_r;
    logic [ADDR_W-1:0]   jump_addr_r;
    logic [N_STAGES-1:0] stall_hold_s;
    logic [N_STAGES-1:0] bubble_s;
    logic [N_STAGES-1:0] flush_pre_s;
    logic [N_STAGES-1:0] stall_s;
    logic [N_STAGES-1:0] flush_s;
    logic                seen_s;
    logic                any_hold_s;
    logic                acc_s;
    logic                pc_hold_s;
    logic                timeout_hit_s;

    // Hold decode: every stage at or below the oldest holder stalls, the next older one takes a bubble
    always_comb begin
        seen_s       = 1'b0;
        stall_hold_s = '0;
        bubble_s     = '0;
        for (int s = N_STAGES - 1; s >= 0; s--) begin
            seen_s          = seen_s | bus.hold_req_i[s];
            stall_hold_s[s] = seen_s;
        end
        for (int s = 0; s < N_STAGES - 1; s++) begin
            bubble_s[s+1] = bus.hold_req_i[s] & ~stall_hold_s[s+1];
        end
    end

    assign any_hold_s = |bus.hold_req_i;
    // A jump from a stalled stage is re-presented later; one seen in SHADOW comes from a bubble.
    assign acc_s      = bus.jump_en_i & ~stall_hold_s[JUMP_STAGE] & (state_r != ST_SHADOW);

    // Stall/flush/pc_hold outputs; flush wins over stall, reset forces a full flush
    always_comb begin
        flush_pre_s = bubble_s
                    | (acc_s ? JUMP_MASK : {N_STAGES{1'b0}})
                    | ((state_r == ST_SHADOW) ? ONE_V : {N_STAGES{1'b0}});
        stall_s     = '0;
        flush_s     = '0;
        pc_hold_s   = 1'b0;
        if (!rst) begin
            flush_s   = {N_STAGES{1'b1}};
            stall_s   = '0;
            pc_hold_s = 1'b0;
        end else begin
            flush_s   = flush_pre_s;
            stall_s   = stall_hold_s & ~flush_pre_s;
            pc_hold_s = any_hold_s & (state_r != ST_SHADOW);
        end
    end

    // Next-state logic and watchdog counter update
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = '0;
        case (state_r)
            ST_IDLE:   state_nxt_s = acc_s ? ST_SHADOW : (any_hold_s ? ST_STALL : ST_IDLE);
            ST_STALL:  state_nxt_s = acc_s ? ST_SHADOW : (any_hold_s ? ST_STALL : ST_IDLE);
            ST_SHADOW: state_nxt_s = any_hold_s ? ST_STALL : ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
        if ((state_r == ST_STALL) && (state_nxt_s == ST_STALL)) begin
            if (hold_cnt_r == CNT_W'(HOLD_TIMEOUT)) begin
                hold_cnt_nxt_s = hold_cnt_r;
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
            end
        end else begin
            hold_cnt_nxt_s = '0;
        end
    end

    assign timeout_hit_s = (state_r == ST_STALL) & any_hold_s
                         & (hold_cnt_r == CNT_W'(HOLD_TIMEOUT - 1));

    // State, redirect and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            hold_cnt_r     <= '0;
            hold_timeout_r <= 1'b0;
            jump_en_r      <= 1'b0;
            jump_addr_r    <= '0;
        end else begin
            state_r        <= state_nxt_s;
            hold_cnt_r     <= hold_cnt_nxt_s;
            hold_timeout_r <= hold_timeout_r | timeout_hit_s;
            jump_en_r      <= acc_s;
            jump_addr_r    <= acc_s ? bus.jump_addr_i : jump_addr_r;
        end
    end

    assign bus.stall_o        = stall_s;
    assign bus.flush_o        = flush_s;
    assign bus.pc_hold_o      = pc_hold_s;
    assign bus.jump_en_o      = jump_en_r;
    assign bus.jump_addr_o    = jump_addr_r;
    assign bus.hold_timeout_o = hold_timeout_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running perf counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + (pc_hold_s ? 32'd1 : 32'd0);
            flush_cnt_r <= flush_cnt_r + (acc_s ? 32'd1 : 32'd0);
        end
    end

    assign bus.stall_cnt_o = stall_cnt_r;
    assign bus.flush_cnt_o = flush_cnt_r;
`else
    assign bus.stall_cnt_o = 32'd0;
    assign bus.flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (N_STAGES=5, JUMP_STAGE=2, HOLD_TIMEOUT=8) with directed vectors.
module tb_pipe_ctrl;
    logic clk;
    logic rst;

    pipe_ctrl_if #(.N_STAGES(5), .ADDR_W(32)) bus ();

    pipe_ctrl #(
        .N_STAGES(5), .ADDR_W(32), .JUMP_STAGE(2), .HOLD_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        pch;
        logic        jen;
        logic [31:0] jaddr;
        logic        tout;
        logic        tchk;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc       = 0;
    int          st_tally  = 0;
    int          fl_tally  = 0;

    localparam logic [31:0] A_A = 32'h8000_0040;
    localparam logic [31:0] A_B = 32'h8000_0080;
    localparam logic [31:0] A_C = 32'h8000_00C0;
    localparam logic [31:0] A_D = 32'h8000_0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s vec%0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    // Issue one cycle of stimulus and queue what the DUT must show in that cycle
    task automatic step(input logic r, input logic [4:0] hold, input logic je, input logic [31:0] ja,
                        input logic [4:0] e_stall, input logic [4:0] e_flush, input logic e_pch,
                        input logic e_jen, input logic [31:0] e_ja, input logic e_tout,
                        input logic e_tchk, input logic e_acc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.hold_req_i  = hold;
        bus.jump_en_i   = je;
        bus.jump_addr_i = ja;
        if (!r) begin
            st_tally = 0;
            fl_tally = 0;
        end
        e.stall = e_stall;
        e.flush = e_flush;
        e.pch   = e_pch;
        e.jen   = e_jen;
        e.jaddr = e_ja;
        e.tout  = e_tout;
        e.tchk  = e_tchk;
`ifdef PIPE_CTRL_PERF_EN
        e.scnt  = 32'(st_tally);
        e.fcnt  = 32'(fl_tally);
`else
        e.scnt  = 32'd0;
        e.fcnt  = 32'd0;
`endif
        st_tally = st_tally + int'(e_pch);
        fl_tally = fl_tally + int'(e_acc);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the head of the scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("stall",     32'(bus.stall_o),   32'(mon_e.stall));
            chk("flush",     32'(bus.flush_o),   32'(mon_e.flush));
            chk("pc_hold",   32'(bus.pc_hold_o), 32'(mon_e.pch));
            chk("jump_en",   32'(bus.jump_en_o), 32'(mon_e.jen));
            chk("jump_addr", bus.jump_addr_o,    mon_e.jaddr);
            if (mon_e.tchk) begin
                chk("timeout", 32'(bus.hold_timeout_o), 32'(mon_e.tout));
            end
            chk("stall_cnt", bus.stall_cnt_o, mon_e.scnt);
            chk("flush_cnt", bus.flush_cnt_o, mon_e.fcnt);
            cyc++;
        end
    end

    initial begin
        rst             = 1'b0;
        bus.hold_req_i  = 5'b00000;
        bus.jump_en_i   = 1'b0;
        bus.jump_addr_i = 32'd0;

        // reset with a pending hold, then release
        step(1'b0, 5'b00100, 1'b0, 32'd0, 5'b00000, 5'b11111, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00100, 1'b0, 32'd0, 5'b00111, 5'b01000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        // plain redirect; the jump seen in SHADOW must be ignored
        step(1'b1, 5'b00000, 1'b1, A_A, 5'b00000, 5'b00011, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'b00000, 1'b1, 32'h0000_1234, 5'b00000, 5'b00001, 1'b0, 1'b1, A_A, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, A_A, 1'b0, 1'b1, 1'b0);
        // jump blocked by an older hold, accepted once the hold drops
        step(1'b1, 5'b01000, 1'b1, A_B, 5'b01111, 5'b10000, 1'b1, 1'b0, A_A, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b1, A_B, 5'b00000, 5'b00011, 1'b0, 1'b0, A_A, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00001, 1'b0, 1'b1, A_B, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, A_B, 1'b0, 1'b1, 1'b0);
        // jump with a younger hold: flush wins; SHADOW with a hold keeps pc_hold low
        step(1'b1, 5'b00001, 1'b1, A_C, 5'b00000, 5'b00011, 1'b1, 1'b0, A_B, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'b00100, 1'b0, 32'd0, 5'b00110, 5'b01001, 1'b0, 1'b1, A_C, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, A_C, 1'b0, 1'b1, 1'b0);
        // long hold trips the watchdog, which stays set after release
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'b00010, 1'b0, 32'd0, 5'b00011, 5'b00100, 1'b1, 1'b0, A_C,
                 (i == 9) ? 1'b1 : 1'b0, (i == 8) ? 1'b0 : 1'b1, 1'b0);
        end
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, A_C, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, A_C, 1'b1, 1'b1, 1'b0);
        // reset during a redirect drops it immediately
        step(1'b1, 5'b00000, 1'b1, A_D, 5'b00000, 5'b00011, 1'b0, 1'b0, A_C, 1'b1, 1'b1, 1'b1);
        step(1'b0, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b11111, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 32'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
